// File: rtl/fifo_sched_pkg.sv
// Shared types and constants for the round-robin FIFO drain scheduler.
package fifo_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    BURST = 2'd2
  } sched_state_t;

  // Output buffer depth; also the bound on words buffered plus in flight.
  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_rr_scheduler_if.sv
// FIFO-side and downstream-stream signals of the scheduler, grouped with modports.
interface fifo_rr_scheduler_if #(
  parameter int NUM_FIFOS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = $clog2(NUM_FIFOS)
);
  logic [NUM_FIFOS-1:0]            fifo_empty;
  logic [NUM_FIFOS-1:0]            fifo_pop;
  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_data;
  logic [DATA_WIDTH-1:0]           out_data;
  logic [ID_WIDTH-1:0]             out_id;
  logic                            out_valid;
  logic                            out_ready;

  modport master (
    input  fifo_empty, fifo_data, out_ready,
    output fifo_pop, out_data, out_id, out_valid
  );

  modport slave (
    output fifo_empty, fifo_data, out_ready,
    input  fifo_pop, out_data, out_id, out_valid
  );
endinterface

// File: rtl/stream_buf2.sv
// Two-entry in-order valid/ready buffer; the head entry drives the output directly.
module stream_buf2
  import fifo_sched_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_payload,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_payload,
  output logic [1:0]       occ
);

  localparam logic [1:0] FULL = 2'(BUF_DEPTH);

  logic [1:0]       occ_r;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] tail_r;
  logic             rd_s;

  assign rd_s        = out_ready & (occ_r != 2'd0);
  assign out_valid   = (occ_r != 2'd0);
  assign out_payload = head_r;
  assign occ         = occ_r;

  // Entry storage; the head only changes when it is consumed or the buffer is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_r  <= 2'd0;
      head_r <= '0;
      tail_r <= '0;
    end else begin
      case (occ_r)
        2'd0: begin
          if (in_valid) begin
            head_r <= in_payload;
            occ_r  <= 2'd1;
          end
        end
        2'd1: begin
          if (in_valid && rd_s) begin
            head_r <= in_payload;
          end else if (in_valid) begin
            tail_r <= in_payload;
            occ_r  <= FULL;
          end else if (rd_s) begin
            occ_r  <= 2'd0;
          end
        end
        FULL: begin
          if (rd_s) begin
            head_r <= tail_r;
            if (in_valid) begin
              tail_r <= in_payload;
            end else begin
              occ_r  <= 2'd1;
            end
          end
        end
        default: occ_r <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin burst drain of NUM_FIFOS read-latency-1 FIFOs onto one tagged valid/ready stream.
module fifo_rr_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int NUM_FIFOS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int ID_WIDTH   = $clog2(NUM_FIFOS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  fifo_rr_scheduler_if.master bus
);

  localparam int                  CNT_WIDTH = $clog2(BURST_LEN + 1);
  localparam logic [ID_WIDTH-1:0] LAST_ID   = ID_WIDTH'(NUM_FIFOS - 1);
  localparam logic [CNT_WIDTH-1:0] BURST_MAX = CNT_WIDTH'(BURST_LEN);

  sched_state_t          state_r, state_s;
  logic [ID_WIDTH-1:0]   rr_ptr_r, rr_ptr_s;
  logic [ID_WIDTH-1:0]   grant_r, grant_s;
  logic [CNT_WIDTH-1:0]  cnt_r, cnt_s;
  logic                  inflight_r;
  logic [ID_WIDTH-1:0]   inflight_id_r;

  logic                  found_s;
  logic [ID_WIDTH-1:0]   found_id_s;
  logic [ID_WIDTH-1:0]   cand_s;
  logic                  pop_s;
  logic                  credit_s;
  logic                  burst_end_s;
  logic                  rd_s;
  logic                  buf_valid_s;
  logic [1:0]            occ_s;
  logic [ID_WIDTH+DATA_WIDTH-1:0] buf_payload_s;
  logic [DATA_WIDTH-1:0] lane_data_s [NUM_FIFOS];

  // Split the flat FIFO data bus into per-lane words.
  always_comb begin
    for (int i = 0; i < NUM_FIFOS; i++) begin
      lane_data_s[i] = bus.fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // First non-empty FIFO at or after rr_ptr; wrap by compare so odd NUM_FIFOS works.
  always_comb begin
    found_s    = 1'b0;
    found_id_s = rr_ptr_r;
    cand_s     = rr_ptr_r;
    for (int k = 0; k < NUM_FIFOS; k++) begin
      cand_s = ((int'(rr_ptr_r) + k) >= NUM_FIFOS) ? ID_WIDTH'(int'(rr_ptr_r) + k - NUM_FIFOS)
                                                   : ID_WIDTH'(int'(rr_ptr_r) + k);
      if (!found_s && !bus.fifo_empty[cand_s]) begin
        found_s    = 1'b1;
        found_id_s = cand_s;
      end else begin
        found_s    = found_s;
      end
    end
  end

  assign rd_s     = buf_valid_s & bus.out_ready;
  assign credit_s = ({1'b0, occ_s} + {2'b00, inflight_r}) < ({2'b00, rd_s} + 3'(BUF_DEPTH));
  assign pop_s    = (state_r == BURST) & enable & ~bus.fifo_empty[grant_r] & credit_s;

  // One-hot pop to the granted FIFO.
  always_comb begin
    bus.fifo_pop          = '0;
    bus.fifo_pop[grant_r] = pop_s;
  end

  // Next-state logic for arbitration and burst accounting.
  always_comb begin
    state_s     = state_r;
    rr_ptr_s    = rr_ptr_r;
    grant_s     = grant_r;
    cnt_s       = cnt_r;
    burst_end_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable && !(&bus.fifo_empty)) begin
          state_s = ARB;
        end else begin
          state_s = IDLE;
        end
      end
      ARB: begin
        if (enable && found_s) begin
          grant_s = found_id_s;
          cnt_s   = '0;
          state_s = BURST;
        end else begin
          state_s = IDLE;
        end
      end
      BURST: begin
        if (pop_s) begin
          cnt_s = cnt_r + CNT_WIDTH'(1);
        end else begin
          cnt_s = cnt_r;
        end
        burst_end_s = (pop_s && ((cnt_r + CNT_WIDTH'(1)) == BURST_MAX))
                    || bus.fifo_empty[grant_r] || !enable;
        if (burst_end_s) begin
          rr_ptr_s = (grant_r == LAST_ID) ? '0 : grant_r + ID_WIDTH'(1);
          state_s  = enable ? ARB : IDLE;
        end else begin
          state_s  = BURST;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State registers; the in-flight tag remembers which lane's word arrives next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      rr_ptr_r      <= '0;
      grant_r       <= '0;
      cnt_r         <= '0;
      inflight_r    <= 1'b0;
      inflight_id_r <= '0;
    end else begin
      state_r       <= state_s;
      rr_ptr_r      <= rr_ptr_s;
      grant_r       <= grant_s;
      cnt_r         <= cnt_s;
      inflight_r    <= pop_s;
      inflight_id_r <= grant_r;
    end
  end

  stream_buf2 #(
    .WIDTH (ID_WIDTH + DATA_WIDTH)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (inflight_r),
    .in_payload  ({inflight_id_r, lane_data_s[inflight_id_r]}),
    .out_ready   (bus.out_ready),
    .out_valid   (buf_valid_s),
    .out_payload (buf_payload_s),
    .occ         (occ_s)
  );

  assign bus.out_valid = buf_valid_s;
  assign bus.out_id    = buf_payload_s[ID_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign bus.out_data  = buf_payload_s[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Scoreboard bench for fifo_rr_scheduler with behavioural read-latency-1 FIFOs.
module tb_fifo_rr_scheduler;
  import fifo_sched_pkg::*;

  localparam int NF = 4;
  localparam int DW = 8;
  localparam int BL = 4;
  localparam int IW = 2;

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic enable = 1'b0;

  fifo_rr_scheduler_if #(.NUM_FIFOS(NF), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  fifo_rr_scheduler #(
    .NUM_FIFOS (NF), .DATA_WIDTH (DW), .BURST_LEN (BL), .ID_WIDTH (IW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Behavioural FIFOs: pop in cycle t presents the word in t+1.
  logic [DW-1:0] mem [NF][64];
  int            wr_ptr [NF];
  int            rd_ptr [NF];
  logic [DW-1:0] rdata [NF];
  int            pop_count = 0;

  always_comb begin
    for (int i = 0; i < NF; i++) begin
      bus.fifo_empty[i]          = (wr_ptr[i] == rd_ptr[i]);
      bus.fifo_data[i*DW +: DW]  = rdata[i];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NF; i++) begin
        rd_ptr[i] <= 0;
        rdata[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NF; i++) begin
        if (bus.fifo_pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + 1;
          rdata[i]  <= mem[i][rd_ptr[i] % 64];
        end
      end
    end
  end

  // Pop legality: one-hot and never on an empty FIFO.
  always @(negedge clk) begin
    if (rst_n && (bus.fifo_pop != '0)) begin
      pop_count <= pop_count + 1;
      check_eq("pop_onehot", 32'($countones(bus.fifo_pop)), 32'd1);
      check_eq("pop_nonempty", 32'(bus.fifo_pop & bus.fifo_empty), 32'd0);
    end
  end

  // Scoreboard: compare every accepted output word with the next expected one.
  logic [IW+DW-1:0] exp_q [$];
  logic [IW+DW-1:0] sb_exp;

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_extra_word", 32'(exp_q.size()), 32'd1);
      end else begin
        sb_exp = exp_q.pop_front();
        check_eq("sb_word", 32'({bus.out_id, bus.out_data}), 32'(sb_exp));
      end
    end
  end

  task automatic push_word(input int f, input logic [DW-1:0] d, input bit exp);
    mem[f][wr_ptr[f] % 64] = d;
    wr_ptr[f] = wr_ptr[f] + 1;
    if (exp) exp_q.push_back({IW'(f), d});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    step(4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] ov_vec, pop_vec;
  int         base, npop, c;

  initial begin
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_pop",   32'(bus.fifo_pop),  32'd0);
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_data",  32'(bus.out_data),  32'd0);
    check_eq("rst_id",    32'(bus.out_id),    32'd0);
    step(3);
    rst_n  = 1'b1;
    enable = 1'b1;
    step(2);
    check_eq("rst_state", 32'(dut.state_r), 32'(IDLE));

    // Single source: latency, throughput, and return to IDLE.
    push_word(2, 8'hA1, 1'b1);
    push_word(2, 8'hB2, 1'b1);
    push_word(2, 8'hC3, 1'b1);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      ov_vec[j]  = bus.out_valid;
      pop_vec[j] = (bus.fifo_pop == 4'b0100);
    end
    check_eq("t1_valid_seq", 32'(ov_vec), 32'h70);
    check_eq("t1_pop_seq",   32'(pop_vec), 32'h1C);
    check_eq("t1_idle",      32'(dut.state_r), 32'(IDLE));
    check_eq("t1_rr",        32'(dut.rr_ptr_r), 32'd3);
    wait_drain("t1", 20);

    // Wrap: rr_ptr is 3, FIFOs 3 and 0 loaded.
    push_word(0, 8'h40, 1'b0);
    push_word(0, 8'h41, 1'b0);
    push_word(3, 8'h30, 1'b1);
    push_word(3, 8'h31, 1'b1);
    exp_q.push_back({2'd0, 8'h40});
    exp_q.push_back({2'd0, 8'h41});
    wait_drain("t2", 40);
    check_eq("t2_rr", 32'(dut.rr_ptr_r), 32'd1);

    // Pointer at 1: FIFO 1 is served before FIFO 0.
    push_word(0, 8'h50, 1'b0);
    push_word(1, 8'h51, 1'b1);
    exp_q.push_back({2'd0, 8'h50});
    wait_drain("t3", 40);
    check_eq("t3_rr", 32'(dut.rr_ptr_r), 32'd1);

    // Backpressure during a burst on FIFO 1.
    bus.out_ready = 1'b0;
    base = pop_count;
    for (int j = 0; j < 6; j++) push_word(1, 8'(8'h60 + j), 1'b1);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!bus.out_valid && c < 20);
    check_eq("t4_valid_seen", 32'(bus.out_valid), 32'd1);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check_eq("t4_hold", 32'({bus.out_id, bus.out_data}), 32'({2'd1, 8'h60}));
    end
    check_eq("t4_pop_low", 32'(bus.fifo_pop), 32'd0);
    check_eq("t4_pops",    32'(pop_count - base), 32'd2);
    step(1);
    bus.out_ready = 1'b1;
    wait_drain("t4", 60);

    // Enable dropped after two pops of a burst on FIFO 2.
    base = pop_count;
    npop = 0;
    for (int j = 0; j < 6; j++) push_word(2, 8'(8'h70 + j), (j < 2));
    c = 0;
    while (npop < 2 && c < 20) begin
      @(negedge clk);
      if (bus.fifo_pop != '0) npop++;
      c++;
    end
    step(1);
    enable = 1'b0;
    step(8);
    check_eq("t5_pops",  32'(pop_count - base), 32'd2);
    check_eq("t5_state", 32'(dut.state_r), 32'(IDLE));
    wait_drain("t5", 20);
    push_word(3, 8'h80, 1'b1);
    for (int j = 2; j < 6; j++) exp_q.push_back({2'd2, 8'(8'h70 + j)});
    enable = 1'b1;
    wait_drain("t5b", 60);

    // Reset while a word is being presented.
    for (int j = 0; j < 4; j++) push_word(0, 8'(8'h90 + j), 1'b1);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!bus.out_valid && c < 20);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_valid", 32'(bus.out_valid), 32'd0);
    check_eq("t6_pop",   32'(bus.fifo_pop),  32'd0);
    check_eq("t6_data",  32'(bus.out_data),  32'd0);
    exp_q.delete();
    for (int i = 0; i < NF; i++) wr_ptr[i] = 0;
    step(2);
    rst_n = 1'b1;
    step(1);
    check_eq("t6_state", 32'(dut.state_r),  32'(IDLE));
    check_eq("t6_rr",    32'(dut.rr_ptr_r), 32'd0);

    // Fairness: six words in every FIFO, bursts of four then the remainder.
    for (int i = 0; i < NF; i++)
      for (int j = 0; j < 6; j++) push_word(i, 8'(i*16 + j), 1'b0);
    for (int i = 0; i < NF; i++)
      for (int j = 0; j < 4; j++) exp_q.push_back({IW'(i), 8'(i*16 + j)});
    for (int i = 0; i < NF; i++)
      for (int j = 4; j < 6; j++) exp_q.push_back({IW'(i), 8'(i*16 + j)});
    wait_drain("t7", 400);
    check_eq("t7_state", 32'(dut.state_r), 32'(IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
